// File: rtl/inst_prefetch_queue_if.sv
// Bundle of fetch-side memory, redirect and decode-side signals for the
// instruction prefetch queue. slave = the queue, master = its environment.
interface inst_prefetch_queue_if #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  i_instr_ready;
    logic [DATA_WIDTH-1:0] i_instr_data;
    logic                  o_inst_rd_en;
    logic [ADDR_WIDTH-1:0] o_inst_addr;
    logic                  i_flush;
    logic [ADDR_WIDTH-1:0] i_flush_addr;
    logic                  o_if_valid;
    logic [DATA_WIDTH-1:0] o_if_inst;
    logic [ADDR_WIDTH-1:0] o_if_pc;
    logic                  i_id_ready;
    logic [CW-1:0]         o_count;

    modport slave (
        input  i_instr_ready, i_instr_data, i_flush, i_flush_addr, i_id_ready,
        output o_inst_rd_en, o_inst_addr, o_if_valid, o_if_inst, o_if_pc, o_count
    );

    modport master (
        output i_instr_ready, i_instr_data, i_flush, i_flush_addr, i_id_ready,
        input  o_inst_rd_en, o_inst_addr, o_if_valid, o_if_inst, o_if_pc, o_count
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Sequential-PC prefetch engine feeding a DEPTH-entry {pc,inst} FIFO for decode.
// Flush redirects fetch, empties the queue and drops any same-cycle memory return.
module inst_prefetch_queue #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic                  clk,
    input logic                  rst,
    inst_prefetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_INIT, S_FETCH, S_HOLD} state_t;

    state_t                r_state;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] r_inst_mem [DEPTH];

    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_accept;

    assign w_valid  = (r_count != '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = w_valid & bus.i_id_ready & ~bus.i_flush;
    // A full queue can only take a new word when the head leaves this cycle.
    assign w_accept = r_rd_en & bus.i_instr_ready & ~bus.i_flush & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
            r_rd_en <= 1'b0;
            r_addr  <= RESET_PC;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.i_flush) begin
            r_state <= S_FETCH;
            r_rd_en <= 1'b1;
            r_addr  <= {bus.i_flush_addr[ADDR_WIDTH-1:2], 2'b00};
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + PW'(1);
                r_addr <= r_addr + ADDR_WIDTH'(4);
            end
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            if (w_accept && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_accept && w_pop)
                r_count <= r_count - CW'(1);

            case (r_state)
                S_INIT: begin
                    r_state <= S_FETCH;
                    r_rd_en <= 1'b1;
                end
                S_FETCH: begin
                    if (w_accept && !w_pop && r_count == CW'(DEPTH - 1)) begin
                        r_state <= S_HOLD;
                        r_rd_en <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (r_count < CW'(DEPTH)) begin
                        r_state <= S_FETCH;
                        r_rd_en <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc_mem[r_wptr]   <= r_addr;
            r_inst_mem[r_wptr] <= bus.i_instr_data;
        end
    end

    assign bus.o_inst_rd_en = r_rd_en;
    assign bus.o_inst_addr  = r_addr;
    assign bus.o_count      = r_count;
    assign bus.o_if_valid   = w_valid;
    assign bus.o_if_pc      = w_valid ? r_pc_mem[r_rptr] : '0;
    assign bus.o_if_inst    = w_valid ? r_inst_mem[r_rptr] : DATA_WIDTH'(32'h0000_0013);
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue: main 32-bit instance plus an 8-bit
// address instance used to exercise PC wrap-around.
module tb_inst_prefetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    inst_prefetch_queue_if #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    inst_prefetch_queue_if #(.DEPTH(4), .ADDR_WIDTH(8),  .DATA_WIDTH(32)) bus2 ();

    inst_prefetch_queue #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0))
        dut (.clk(clk), .rst(rst), .bus(bus));
    inst_prefetch_queue #(.DEPTH(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(8'hF8))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory returns a word derived from the requested address.
    assign bus.i_instr_data  = memf(bus.o_inst_addr);
    assign bus2.i_instr_data = memf({24'h0, bus2.o_inst_addr});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0 (INIT) with reset just released.
    task automatic do_reset();
        rst = 1'b1;
        bus.i_flush = 1'b0;
        bus.i_flush_addr = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_instr_ready = 1'b1;
        bus.i_id_ready    = 1'b1;
        rst = 1'b1;
        bus.i_flush = 1'b0;
        bus.i_flush_addr = '0;
        tick();
        n_cmp++; if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.o_count); end
        n_cmp++; if (bus.o_if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.o_if_valid); end
        n_cmp++; if (bus.o_inst_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %b want 0", bus.o_inst_rd_en); end
        n_cmp++; if (bus.o_inst_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", bus.o_inst_addr); end
        n_cmp++; if (bus.o_if_inst !== 32'h13) begin n_err++; $display("FAIL reset_nop got %h want 00000013", bus.o_if_inst); end
        rst = 1'b0;
        n_cmp++; if (bus.o_inst_rd_en !== 1'b0) begin n_err++; $display("FAIL init_rd_en got %b want 0", bus.o_inst_rd_en); end
        tick();
        n_cmp++; if (bus.o_inst_rd_en !== 1'b1) begin n_err++; $display("FAIL c1_rd_en got %b want 1", bus.o_inst_rd_en); end
        n_cmp++; if (bus.o_inst_addr !== 32'h0) begin n_err++; $display("FAIL c1_addr got %h want 0", bus.o_inst_addr); end
    endtask

    // Continues from test_reset at cycle 1 with memory and decode always ready.
    task automatic test_stream();
        logic [31:0] epc;
        for (int k = 2; k <= 6; k++) begin
            tick();
            epc = 32'(4 * (k - 2));
            n_cmp++; if (bus.o_if_pc !== epc) begin n_err++; $display("FAIL stream_pc c%0d got %h want %h", k, bus.o_if_pc, epc); end
            n_cmp++; if (bus.o_if_inst !== memf(epc)) begin n_err++; $display("FAIL stream_inst c%0d got %h want %h", k, bus.o_if_inst, memf(epc)); end
            n_cmp++; if (bus.o_count !== 3'd1) begin n_err++; $display("FAIL stream_count c%0d got %0d want 1", k, bus.o_count); end
        end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc [4];
        bus.i_instr_ready = 1'b1;
        bus.i_id_ready    = 1'b0;
        do_reset();
        for (int c = 1; c <= 5; c++) tick();
        for (int c = 5; c <= 7; c++) begin
            n_cmp++; if (bus.o_count !== 3'd4) begin n_err++; $display("FAIL full_count c%0d got %0d want 4", c, bus.o_count); end
            n_cmp++; if (bus.o_inst_rd_en !== 1'b0) begin n_err++; $display("FAIL full_rd_en c%0d got %b want 0", c, bus.o_inst_rd_en); end
            n_cmp++; if (bus.o_inst_addr !== 32'h10) begin n_err++; $display("FAIL full_addr c%0d got %h want 10", c, bus.o_inst_addr); end
            n_cmp++; if (bus.o_if_pc !== 32'h0) begin n_err++; $display("FAIL full_head c%0d got %h want 0", c, bus.o_if_pc); end
            if (c < 7) tick();
        end
        bus.i_id_ready = 1'b1;
        tick();
        bus.i_id_ready = 1'b0;
        n_cmp++; if (bus.o_count !== 3'd3) begin n_err++; $display("FAIL pop1_count got %0d want 3", bus.o_count); end
        n_cmp++; if (bus.o_if_pc !== 32'h4) begin n_err++; $display("FAIL pop1_head got %h want 4", bus.o_if_pc); end
        tick();
        n_cmp++; if (bus.o_inst_rd_en !== 1'b1) begin n_err++; $display("FAIL resume_rd_en got %b want 1", bus.o_inst_rd_en); end
        n_cmp++; if (bus.o_inst_addr !== 32'h10) begin n_err++; $display("FAIL resume_addr got %h want 10", bus.o_inst_addr); end
        tick();
        n_cmp++; if (bus.o_count !== 3'd4) begin n_err++; $display("FAIL refill_count got %0d want 4", bus.o_count); end
        n_cmp++; if (bus.o_inst_addr !== 32'h14) begin n_err++; $display("FAIL refill_addr got %h want 14", bus.o_inst_addr); end
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC; exp_pc[3] = 32'h10;
        bus.i_id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.o_if_pc !== exp_pc[i]) begin n_err++; $display("FAIL drain_pc %0d got %h want %h", i, bus.o_if_pc, exp_pc[i]); end
            tick();
        end
    endtask

    task automatic test_slow();
        logic [31:0] ea;
        logic        ev;
        bus.i_id_ready    = 1'b1;
        bus.i_instr_ready = 1'b0;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            tick();
            ea = 32'(4 * ((c - 1) / 3));
            ev = (c >= 4) && (c % 3 == 1);
            n_cmp++; if (bus.o_inst_addr !== ea) begin n_err++; $display("FAIL slow_addr c%0d got %h want %h", c, bus.o_inst_addr, ea); end
            n_cmp++; if (bus.o_if_valid !== ev) begin n_err++; $display("FAIL slow_valid c%0d got %b want %b", c, bus.o_if_valid, ev); end
            if (ev) begin
                n_cmp++; if (bus.o_if_pc !== 32'(4 * ((c - 4) / 3))) begin n_err++; $display("FAIL slow_pc c%0d got %h want %h", c, bus.o_if_pc, 32'(4 * ((c - 4) / 3))); end
            end
            bus.i_instr_ready = (c % 3 == 0);
        end
    endtask

    task automatic test_flush();
        bus.i_id_ready    = 1'b0;
        bus.i_instr_ready = 1'b1;
        do_reset();
        for (int c = 1; c <= 4; c++) tick();
        n_cmp++; if (bus.o_count !== 3'd3) begin n_err++; $display("FAIL preflush_count got %0d want 3", bus.o_count); end
        bus.i_flush = 1'b1;
        bus.i_flush_addr = 32'h0000_0103;
        tick();
        bus.i_flush = 1'b0;
        n_cmp++; if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", bus.o_count); end
        n_cmp++; if (bus.o_if_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", bus.o_if_valid); end
        n_cmp++; if (bus.o_inst_addr !== 32'h100) begin n_err++; $display("FAIL flush_addr got %h want 100", bus.o_inst_addr); end
        n_cmp++; if (bus.o_inst_rd_en !== 1'b1) begin n_err++; $display("FAIL flush_rd_en got %b want 1", bus.o_inst_rd_en); end
        tick();
        n_cmp++; if (bus.o_if_pc !== 32'h100) begin n_err++; $display("FAIL flush_head got %h want 100", bus.o_if_pc); end
        n_cmp++; if (bus.o_if_inst !== memf(32'h100)) begin n_err++; $display("FAIL flush_inst got %h want %h", bus.o_if_inst, memf(32'h100)); end
        n_cmp++; if (bus.o_count !== 3'd1) begin n_err++; $display("FAIL flush_newcount got %0d want 1", bus.o_count); end
        bus.i_flush = 1'b1;
        bus.i_flush_addr = 32'h200;
        tick();
        bus.i_flush_addr = 32'h306;
        tick();
        bus.i_flush = 1'b0;
        n_cmp++; if (bus.o_inst_addr !== 32'h304) begin n_err++; $display("FAIL b2b_flush_addr got %h want 304", bus.o_inst_addr); end
        n_cmp++; if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL b2b_flush_count got %0d want 0", bus.o_count); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [4];
        exp_pc[0] = 8'hF8; exp_pc[1] = 8'hFC; exp_pc[2] = 8'h00; exp_pc[3] = 8'h04;
        bus.i_instr_ready = 1'b0;
        bus.i_id_ready    = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (bus2.o_if_pc !== exp_pc[i]) begin n_err++; $display("FAIL wrap_pc %0d got %h want %h", i, bus2.o_if_pc, exp_pc[i]); end
        end
    endtask

    task automatic test_reset_mid();
        bus.i_id_ready    = 1'b0;
        bus.i_instr_ready = 1'b1;
        do_reset();
        for (int c = 1; c <= 4; c++) tick();
        n_cmp++; if (bus.o_count !== 3'd3) begin n_err++; $display("FAIL mid_pre_count got %0d want 3", bus.o_count); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.o_if_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", bus.o_if_valid); end
        n_cmp++; if (bus.o_count !== 3'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", bus.o_count); end
        n_cmp++; if (bus.o_inst_addr !== 32'h0) begin n_err++; $display("FAIL mid_addr got %h want 0", bus.o_inst_addr); end
        n_cmp++; if (bus2.o_inst_addr !== 8'hF8) begin n_err++; $display("FAIL mid_addr2 got %h want f8", bus2.o_inst_addr); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus2.i_instr_ready = 1'b1;
        bus2.i_id_ready    = 1'b1;
        bus2.i_flush       = 1'b0;
        bus2.i_flush_addr  = '0;
        test_reset();
        test_stream();
        test_full();
        test_slow();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
